exmpl3_driver: RTL and testbench

EXMPL3_DRIVER -- requirements
Module: exmpl3_driver

---
 rtl/exmpl3_pkg.sv | 21 ++
 rtl/exmpl3_golden.sv | 17 +
 rtl/exmpl3_driver.sv | 133 +++++++++++++
 tb/tb_exmpl3_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exmpl3_pkg.sv
// Shared definitions for the exmpl3 gate-block test driver.
package exmpl3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned NUM_VEC    = 8;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;

  // Mismatch counter never exceeds NUM_VEC; saturate rather than wrap.
  function automatic logic [3:0] err_inc(input logic [3:0] e);
    return (e >= 4'(NUM_VEC)) ? e : e + 4'd1;
  endfunction

endpackage

// File: rtl/exmpl3_golden.sv
// Expected response of the gate block under test for a given stimulus.
module exmpl3_golden
  import exmpl3_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic C,
  output logic D,
  output logic F,
  output logic G
);

  assign D = A & B;
  assign F = B | C;
  assign G = ~A;

endmodule

// File: rtl/exmpl3_driver.sv
// Exhaustive 3-input stimulus driver: walks all 8 vectors, compares the
// gate block's D/F/G against the golden model and reports per-vector results.
module exmpl3_driver
  import exmpl3_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       D,
  input  logic       F,
  input  logic       G,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic [2:0] abc_nxt;
  logic       busy_nxt, done_nxt, pass_nxt;
  logic [3:0] err_nxt;
  logic [7:0] fv_nxt;
  logic       exp_d, exp_f, exp_g;
  logic       mismatch;

  exmpl3_golden u_golden (
    .A (A),
    .B (B),
    .C (C),
    .D (exp_d),
    .F (exp_f),
    .G (exp_g)
  );

  assign mismatch = ({D, F, G} != {exp_d, exp_f, exp_g});

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    abc_nxt   = {A, B, C};
    err_nxt   = err_count;
    fv_nxt    = fail_vec;
    pass_nxt  = pass;

    unique case (state)
      ST_IDLE: begin
        abc_nxt = '0;
        if (start) begin
          state_nxt = ST_APPLY;
          idx_nxt   = '0;
          err_nxt   = '0;
          fv_nxt    = '0;
          pass_nxt  = 1'b0;
        end
      end
      ST_APPLY: begin
        state_nxt = ST_WAIT;
        wcnt_nxt  = SETTLE_L;
      end
      ST_WAIT: begin
        if (wcnt <= 4'd1) begin
          state_nxt = ST_CHECK;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          fv_nxt[idx] = 1'b1;
          err_nxt     = err_inc(err_count);
        end
        if (idx == LAST_IDX) begin
          state_nxt = ST_DONE;
          abc_nxt   = '0;
          pass_nxt  = (err_nxt == 4'd0);
        end else begin
          state_nxt = ST_APPLY;
          idx_nxt   = idx + 3'd1;
          abc_nxt   = idx + 3'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        abc_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      wcnt      <= '0;
      {A, B, C} <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      wcnt      <= wcnt_nxt;
      {A, B, C} <= abc_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_vec  <= fv_nxt;
    end
  end

endmodule

// File: tb/tb_exmpl3_driver.sv
// Randomized self-checking bench for exmpl3_driver with a cycle-offset run model.
module tb_exmpl3_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, a_o, b_o, c_o, d_i, f_i, g_i, busy, done, pass;
  logic [3:0] err [2];
  logic [7:0] fv  [2];

  exmpl3_driver #(.SETTLE(1)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .A(a_o[0]), .B(b_o[0]), .C(c_o[0]),
    .D(d_i[0]), .F(f_i[0]), .G(g_i[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .fail_vec(fv[0])
  );

  exmpl3_driver #(.SETTLE(3)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .A(a_o[1]), .B(b_o[1]), .C(c_o[1]),
    .D(d_i[1]), .F(f_i[1]), .G(g_i[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .fail_vec(fv[1])
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Gate-under-test configuration: 0 correct, 1 G stuck at 0, 2 D inverted, 3 random xor per vector.
  int unsigned fmode [2];
  logic [2:0]  xtab  [2][8];
  logic [2:0]  noise [2];

  function automatic int unsigned settle_of(input int unsigned i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned run_len(input int unsigned i);
    return 8 * (settle_of(i) + 2) + 1;
  endfunction

  function automatic logic [2:0] good_resp(input logic [2:0] v);
    return {v[2] & v[1], v[1] | v[0], ~v[2]};
  endfunction

  function automatic logic [2:0] gate_resp(input int unsigned mode, input logic [2:0] x,
                                           input logic [2:0] v);
    logic [2:0] r;
    r = good_resp(v);
    case (mode)
      1: r[0] = 1'b0;
      2: r[2] = ~r[2];
      3: r = r ^ x;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] popc(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int b = 0; b < 8; b++) n = n + 4'(m[b]);
    return n;
  endfunction

  function automatic logic [7:0] calc_mask(input int unsigned i);
    logic [7:0] m;
    for (int v = 0; v < 8; v++)
      m[v] = (gate_resp(fmode[i], xtab[i][v], 3'(v)) != good_resp(3'(v)));
    return m;
  endfunction

  function automatic bit in_check(input int unsigned i, input int unsigned kk);
    int unsigned s;
    s = settle_of(i);
    return (kk >= 1) && (kk < run_len(i)) && (((kk - 1) % (s + 2)) == s + 1);
  endfunction

  // Run model: k = cycles since the accepting edge (0 = idle).
  int unsigned k     [2];
  logic [7:0]  mask  [2];
  logic [7:0]  hfv   [2];
  logic [3:0]  herr  [2];
  logic        hpass [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        k[i] <= 0; hfv[i] <= '0; herr[i] <= '0; hpass[i] <= 1'b0; mask[i] <= '0;
      end else if (k[i] == 0) begin
        if (start[i]) begin
          k[i] <= 1; mask[i] <= calc_mask(i);
          hfv[i] <= '0; herr[i] <= '0; hpass[i] <= 1'b0;
        end
      end else if (k[i] == run_len(i)) begin
        k[i] <= 0; hfv[i] <= mask[i]; herr[i] <= popc(mask[i]); hpass[i] <= (mask[i] == 8'h00);
      end else begin
        k[i] <= k[i] + 1;
      end
    end
  end

  // Expected {abc[17:15], busy, done, pass, err[11:8], fail_vec[7:0]}.
  function automatic logic [17:0] model_out(input int unsigned i);
    int unsigned s, L, kk, v;
    logic [7:0] m;
    s = settle_of(i); L = run_len(i); kk = k[i];
    if (kk == 0) return {3'b000, 1'b0, 1'b0, hpass[i], herr[i], hfv[i]};
    if (kk == L) return {3'b000, 1'b1, 1'b1, (mask[i] == 8'h00), popc(mask[i]), mask[i]};
    v = (kk - 1) / (s + 2);
    m = '0;
    for (int w = 0; w < 8; w++)
      if ((w + 1) * (s + 2) < kk) m[w] = mask[i][w];
    return {3'(v), 1'b1, 1'b0, 1'b0, popc(m), m};
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 2; i++) noise[i] <= 3'($urandom);

  always_comb begin
    logic [2:0] r;
    d_i = '0; f_i = '0; g_i = '0; r = '0;
    for (int i = 0; i < 2; i++) begin
      r = in_check(i, k[i]) ?
          gate_resp(fmode[i], xtab[i][{a_o[i], b_o[i], c_o[i]}], {a_o[i], b_o[i], c_o[i]}) :
          noise[i];
      d_i[i] = r[2]; f_i[i] = r[1]; g_i[i] = r[0];
    end
  end

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, i, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [17:0] e;
        e = model_out(i);
        chk("abc",       i, {a_o[i], b_o[i], c_o[i]}, e[17:15]);
        chk("busy",      i, busy[i],                 e[14]);
        chk("done",      i, done[i],                 e[13]);
        chk("pass",      i, pass[i],                 e[12]);
        chk("err_count", i, err[i],                  e[11:8]);
        chk("fail_vec",  i, fv[i],                   e[7:0]);
      end
    end
  end

  task automatic run(input int i, input bit poke, output int cyc);
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      if (done[i] === 1'b1) begin cyc = n; break; end
      if (poke) start[i] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start[i] = 1'b0;
  endtask

  task automatic randomize_xtab(input int i);
    for (int v = 0; v < 8; v++)
      xtab[i][v] = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'($urandom_range(1, 7));
  endtask

  initial begin
    int cyc, d1, d2;
    rst = 2'b11; start = 2'b00;
    fmode[0] = 0; fmode[1] = 0;
    for (int i = 0; i < 2; i++) for (int v = 0; v < 8; v++) xtab[i][v] = '0;
    @(negedge clk); @(negedge clk);
    check_en = 1'b1;
    @(negedge clk); rst = 2'b00;
    chk("reset_busy", 0, busy[0], 1'b0);
    chk("reset_err",  0, err[0],  4'd0);

    fmode[0] = 0; run(0, 1'b0, cyc);
    chk("latency_good", 0, cyc, 25);
    chk("good_pass", 0, pass[0], 1'b1);
    chk("good_err",  0, err[0],  4'd0);
    chk("good_fv",   0, fv[0],   8'h00);

    fmode[0] = 1; run(0, 1'b0, cyc);
    chk("gstuck_fv",   0, fv[0],   8'h0F);
    chk("gstuck_err",  0, err[0],  4'd4);
    chk("gstuck_pass", 0, pass[0], 1'b0);

    fmode[0] = 2; run(0, 1'b0, cyc);
    chk("dinv_fv",   0, fv[0],   8'hFF);
    chk("dinv_err",  0, err[0],  4'd8);
    chk("dinv_pass", 0, pass[0], 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_fv",  0, fv[0],  8'hFF);
    chk("hold_err", 0, err[0], 4'd8);

    for (int r = 0; r < 6; r++) begin
      fmode[0] = 3; randomize_xtab(0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(0, 1'b1, cyc);
      chk("latency_rand", 0, cyc, run_len(0));
    end

    fmode[0] = 2;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_err", 0, err[0], 4'd3);
    rst[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0; start[0] = 1'b0;
    chk("midrst_busy", 0, busy[0], 1'b0);
    chk("midrst_abc",  0, {a_o[0], b_o[0], c_o[0]}, 3'b000);
    chk("midrst_err",  0, err[0], 4'd0);
    chk("midrst_fv",   0, fv[0],  8'h00);
    @(negedge clk);
    chk("rst_start_discarded", 0, busy[0], 1'b0);
    fmode[0] = 0; run(0, 1'b0, cyc);
    chk("latency_after_rst", 0, cyc, 25);
    chk("after_rst_pass", 0, pass[0], 1'b1);

    fmode[1] = 3; randomize_xtab(1);
    @(negedge clk); rst[1] = 1'b1;
    @(negedge clk); rst[1] = 1'b0; start[1] = 1'b1;
    d1 = 0; d2 = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done[1] === 1'b1) begin
        if (d1 == 0) d1 = n;
        else begin d2 = n; break; end
      end
    end
    start[1] = 1'b0;
    chk("held_done_first",  1, d1, 41);
    chk("held_done_second", 1, d2, 83);

    repeat (50) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
